// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and stage-control unit for the 5-stage MIPS pipeline:
// ID forwarding selects, load-use / multi-cycle MD stalls, branch flush, debug freeze.
module pipe_hazard_unit #(
  parameter int ADDR_W     = 5,
  parameter int MD_LAT     = 4,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [ADDR_W-1:0] id_addr_rs,
  input  logic [ADDR_W-1:0] id_addr_rt,
  input  logic              id_is_store,
  input  logic              id_is_md,
  input  logic              id_redirect,
  input  logic [ADDR_W-1:0] exe_regw_addr,
  input  logic              exe_wb_wen,
  input  logic              exe_is_load,
  input  logic [ADDR_W-1:0] mem_regw_addr,
  input  logic              mem_wb_wen,
  input  logic              mem_is_load,
  input  logic              mem_is_store,
  input  logic [ADDR_W-1:0] mem_addr_rt,
  input  logic [ADDR_W-1:0] wb_regw_addr,
  input  logic              wb_wen,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_mem,
  output logic              if_rst,
  output logic              if_en,
  output logic              id_rst,
  output logic              id_en,
  output logic              exe_rst,
  output logic              exe_en,
  output logic              mem_rst,
  output logic              mem_en,
  output logic              wb_rst,
  output logic              wb_en,
  output logic              stall,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // md_cnt counts the MD_BUSY cycles still to go after the current one
  localparam int MDW = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;
  localparam logic [MDW-1:0] MD_RELOAD = MDW'((MD_LAT > 1) ? (MD_LAT - 2) : 0);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t           state_r, state_next_s;
  logic [MDW-1:0]   md_cnt_r, md_cnt_next_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             debug_step_prev_r;

  logic             exe_a_s, exe_b_s, mem_a_s, mem_b_s;
  logic             load_stall_s, frozen_s;
  logic [1:0]       fwd_a_s, fwd_b_s;
  logic             fwd_mem_s;

  function automatic logic src_match(input logic used, input logic [ADDR_W-1:0] src,
                                     input logic [ADDR_W-1:0] dst, input logic wen);
    return used & (src != '0) & wen & (dst == src);
  endfunction

  assign frozen_s  = debug_en & ~(debug_step & ~debug_step_prev_r);
  assign md_busy   = (state_r == MD_BUSY);
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

  // Source matches against EXE/MEM destinations and the resulting forward selects.
  always_comb begin
    exe_a_s = src_match(id_rs_used, id_addr_rs, exe_regw_addr, exe_wb_wen);
    exe_b_s = src_match(id_rt_used, id_addr_rt, exe_regw_addr, exe_wb_wen);
    mem_a_s = src_match(id_rs_used, id_addr_rs, mem_regw_addr, mem_wb_wen);
    mem_b_s = src_match(id_rt_used, id_addr_rt, mem_regw_addr, mem_wb_wen);
    // a store's rt from an EXE load is patched in MEM via fwd_mem, so no stall
    load_stall_s = exe_is_load & (exe_a_s | (exe_b_s & ~id_is_store));
    fwd_mem_s = mem_is_store & (mem_addr_rt != '0) & wb_wen & (wb_regw_addr == mem_addr_rt);
    fwd_a_s = 2'd0;
    if (exe_a_s) begin
      fwd_a_s = exe_is_load ? 2'd0 : 2'd1;
    end else if (mem_a_s) begin
      fwd_a_s = mem_is_load ? 2'd3 : 2'd2;
    end else begin
      fwd_a_s = 2'd0;
    end
    fwd_b_s = 2'd0;
    if (exe_b_s) begin
      fwd_b_s = exe_is_load ? 2'd0 : 2'd1;
    end else if (mem_b_s) begin
      fwd_b_s = mem_is_load ? 2'd3 : 2'd2;
    end else begin
      fwd_b_s = 2'd0;
    end
  end

  // Stage controls and FSM next state, in priority reset > freeze > busy > load-use > flush.
  always_comb begin
    if_rst = 1'b0; id_rst = 1'b0; exe_rst = 1'b0; mem_rst = 1'b0; wb_rst = 1'b0;
    if_en  = 1'b1; id_en  = 1'b1; exe_en  = 1'b1; mem_en  = 1'b1; wb_en  = 1'b1;
    stall = 1'b0;
    fwd_a = fwd_a_s;
    fwd_b = fwd_b_s;
    fwd_mem = fwd_mem_s;
    state_next_s = state_r;
    md_cnt_next_s = md_cnt_r;
    if (!rst) begin
      if_rst = 1'b1; id_rst = 1'b1; exe_rst = 1'b1; mem_rst = 1'b1; wb_rst = 1'b1;
      fwd_a = 2'd0;
      fwd_b = 2'd0;
      fwd_mem = 1'b0;
    end else if (frozen_s) begin
      if_en = 1'b0; id_en = 1'b0; exe_en = 1'b0; mem_en = 1'b0; wb_en = 1'b0;
    end else begin
      case (state_r)
        MD_BUSY: begin
          if_en = 1'b0; id_en = 1'b0; exe_en = 1'b0;
          mem_rst = 1'b1;
          stall = 1'b1;
          if (md_cnt_r == '0) begin
            state_next_s = IDLE;
          end else begin
            md_cnt_next_s = md_cnt_r - MDW'(1);
          end
        end
        IDLE: begin
          if (load_stall_s) begin
            if_en = 1'b0; id_en = 1'b0;
            exe_rst = 1'b1;
            stall = 1'b1;
          end else begin
            if (id_is_md && (MD_LAT > 1)) begin
              state_next_s = MD_BUSY;
              md_cnt_next_s = MD_RELOAD;
            end else begin
              state_next_s = IDLE;
            end
            if ((DELAY_SLOT == 0) && id_redirect) begin
              if_rst = 1'b1;
            end else begin
              if_rst = 1'b0;
            end
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // FSM, MD counter, step-edge history and saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      md_cnt_r <= '0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
      debug_step_prev_r <= 1'b0;
    end else begin
      debug_step_prev_r <= debug_step;
      state_r <= state_next_s;
      md_cnt_r <= md_cnt_next_s;
      if (!frozen_s && stall && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (!frozen_s && if_rst && (flush_cnt_r != '1)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_unit;
  localparam int AW  = 5;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst, debug_en, debug_step, id_rs_used, id_rt_used, id_is_store, id_is_md, id_redirect;
  logic [AW-1:0] id_addr_rs, id_addr_rt, exe_regw_addr, mem_regw_addr, mem_addr_rt, wb_regw_addr;
  logic exe_wb_wen, exe_is_load, mem_wb_wen, mem_is_load, mem_is_store, wb_wen;
  logic [1:0] fwd_a, fwd_b, ds_fwd_a, ds_fwd_b;
  logic fwd_mem, if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en;
  logic stall, md_busy;
  logic [31:0] stall_cnt, flush_cnt;
  logic ds_fwd_mem, ds_if_rst, ds_if_en, ds_id_rst, ds_id_en, ds_exe_rst, ds_exe_en;
  logic ds_mem_rst, ds_mem_en, ds_wb_rst, ds_wb_en, ds_stall, ds_md_busy;
  logic [1:0] ds_stall_cnt, ds_flush_cnt;
  logic [4:0] ens, rsts, ds_ens, ds_rsts;
  int errors = 0;
  int checks = 0;

  assign ens     = {if_en, id_en, exe_en, mem_en, wb_en};
  assign rsts    = {if_rst, id_rst, exe_rst, mem_rst, wb_rst};
  assign ds_ens  = {ds_if_en, ds_id_en, ds_exe_en, ds_mem_en, ds_wb_en};
  assign ds_rsts = {ds_if_rst, ds_id_rst, ds_exe_rst, ds_mem_rst, ds_wb_rst};

  pipe_hazard_unit #(.ADDR_W(AW), .MD_LAT(LAT), .DELAY_SLOT(0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_addr_rs(id_addr_rs), .id_addr_rt(id_addr_rt),
    .id_is_store(id_is_store), .id_is_md(id_is_md), .id_redirect(id_redirect),
    .exe_regw_addr(exe_regw_addr), .exe_wb_wen(exe_wb_wen), .exe_is_load(exe_is_load),
    .mem_regw_addr(mem_regw_addr), .mem_wb_wen(mem_wb_wen), .mem_is_load(mem_is_load),
    .mem_is_store(mem_is_store), .mem_addr_rt(mem_addr_rt), .wb_regw_addr(wb_regw_addr), .wb_wen(wb_wen),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_mem(fwd_mem),
    .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en), .exe_rst(exe_rst), .exe_en(exe_en),
    .mem_rst(mem_rst), .mem_en(mem_en), .wb_rst(wb_rst), .wb_en(wb_en),
    .stall(stall), .md_busy(md_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  // Delay-slot variant with 2-bit counters, sharing the same inputs
  pipe_hazard_unit #(.ADDR_W(AW), .MD_LAT(LAT), .DELAY_SLOT(1), .CNT_W(2)) dut_ds (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_addr_rs(id_addr_rs), .id_addr_rt(id_addr_rt),
    .id_is_store(id_is_store), .id_is_md(id_is_md), .id_redirect(id_redirect),
    .exe_regw_addr(exe_regw_addr), .exe_wb_wen(exe_wb_wen), .exe_is_load(exe_is_load),
    .mem_regw_addr(mem_regw_addr), .mem_wb_wen(mem_wb_wen), .mem_is_load(mem_is_load),
    .mem_is_store(mem_is_store), .mem_addr_rt(mem_addr_rt), .wb_regw_addr(wb_regw_addr), .wb_wen(wb_wen),
    .fwd_a(ds_fwd_a), .fwd_b(ds_fwd_b), .fwd_mem(ds_fwd_mem),
    .if_rst(ds_if_rst), .if_en(ds_if_en), .id_rst(ds_id_rst), .id_en(ds_id_en), .exe_rst(ds_exe_rst),
    .exe_en(ds_exe_en), .mem_rst(ds_mem_rst), .mem_en(ds_mem_en), .wb_rst(ds_wb_rst), .wb_en(ds_wb_en),
    .stall(ds_stall), .md_busy(ds_md_busy), .stall_cnt(ds_stall_cnt), .flush_cnt(ds_flush_cnt));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    debug_en = 1'b0; debug_step = 1'b0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_addr_rs = '0; id_addr_rt = '0; id_is_store = 1'b0; id_is_md = 1'b0; id_redirect = 1'b0;
    exe_regw_addr = '0; exe_wb_wen = 1'b0; exe_is_load = 1'b0;
    mem_regw_addr = '0; mem_wb_wen = 1'b0; mem_is_load = 1'b0; mem_is_store = 1'b0;
    mem_addr_rt = '0; wb_regw_addr = '0; wb_wen = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    exe_regw_addr = 5'd3; exe_wb_wen = 1'b1; exe_is_load = 1'b1;
    id_rs_used = 1'b1; id_addr_rs = 5'd3; id_is_md = 1'b1; id_redirect = 1'b1;
    mem_is_store = 1'b1; mem_addr_rt = 5'd2; wb_wen = 1'b1; wb_regw_addr = 5'd2;
    settle();
    checks++; if (rsts !== 5'h1f) begin errors++; $display("FAIL reset_rsts: got %b want 11111", rsts); end
    checks++; if (ens !== 5'h1f) begin errors++; $display("FAIL reset_ens: got %b want 11111", ens); end
    checks++; if ({fwd_a, fwd_b, fwd_mem, stall} !== 6'd0) begin errors++;
      $display("FAIL reset_fwd: got fwd_a=%0d fwd_b=%0d fwd_mem=%0b stall=%0b want 0", fwd_a, fwd_b, fwd_mem, stall); end
    tick();
    checks++; if (md_busy !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++;
      $display("FAIL reset_state: got md_busy=%0b stall_cnt=%0d flush_cnt=%0d want 0", md_busy, stall_cnt, flush_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_forward();
    do_reset();
    exe_regw_addr = 5'd3; exe_wb_wen = 1'b1;
    id_rs_used = 1'b1; id_rt_used = 1'b1; id_addr_rs = 5'd3; id_addr_rt = 5'd3;
    mem_regw_addr = 5'd3; mem_wb_wen = 1'b1;
    settle();
    checks++; if (fwd_a !== 2'd1 || fwd_b !== 2'd1 || stall !== 1'b0) begin errors++;
      $display("FAIL fwd_exe: got a=%0d b=%0d stall=%0b want 1 1 0", fwd_a, fwd_b, stall); end
    tick();
    exe_regw_addr = 5'd9; id_addr_rt = 5'd7; mem_regw_addr = 5'd7; mem_is_load = 1'b0;
    settle();
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd2) begin errors++;
      $display("FAIL fwd_mem_alu: got a=%0d b=%0d want 0 2", fwd_a, fwd_b); end
    tick();
    mem_is_load = 1'b1; id_addr_rs = 5'd7;
    settle();
    checks++; if (fwd_a !== 2'd3 || fwd_b !== 2'd3 || stall !== 1'b0) begin errors++;
      $display("FAIL fwd_mem_load: got a=%0d b=%0d stall=%0b want 3 3 0", fwd_a, fwd_b, stall); end
    tick();
    id_addr_rs = 5'd0; id_addr_rt = 5'd0; exe_regw_addr = 5'd0; mem_regw_addr = 5'd0;
    settle();
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++;
      $display("FAIL fwd_r0: got a=%0d b=%0d want 0 0", fwd_a, fwd_b); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    exe_regw_addr = 5'd5; exe_wb_wen = 1'b1; exe_is_load = 1'b1;
    id_rs_used = 1'b1; id_addr_rs = 5'd5; id_redirect = 1'b1;
    settle();
    checks++; if (ens !== 5'b00111 || rsts !== 5'b00100 || stall !== 1'b1) begin errors++;
      $display("FAIL lu_ctl: got ens=%b rsts=%b stall=%0b want 00111 00100 1", ens, rsts, stall); end
    tick();
    checks++; if (stall_cnt !== 32'd1 || flush_cnt !== 32'd0) begin errors++;
      $display("FAIL lu_cnt: got stall_cnt=%0d flush_cnt=%0d want 1 0", stall_cnt, flush_cnt); end
    exe_wb_wen = 1'b0; exe_is_load = 1'b0; id_redirect = 1'b0;
    mem_regw_addr = 5'd5; mem_wb_wen = 1'b1; mem_is_load = 1'b1;
    settle();
    checks++; if (fwd_a !== 2'd3 || stall !== 1'b0 || ens !== 5'h1f) begin errors++;
      $display("FAIL lu_next: got fwd_a=%0d stall=%0b ens=%b want 3 0 11111", fwd_a, stall, ens); end
    tick();
  endtask

  task automatic test_store();
    do_reset();
    exe_regw_addr = 5'd5; exe_wb_wen = 1'b1; exe_is_load = 1'b1;
    id_is_store = 1'b1; id_rs_used = 1'b1; id_addr_rs = 5'd0; id_rt_used = 1'b1; id_addr_rt = 5'd5;
    settle();
    checks++; if (stall !== 1'b0 || ens !== 5'h1f || fwd_a !== 2'd0) begin errors++;
      $display("FAIL st_nostall: got stall=%0b ens=%b fwd_a=%0d want 0 11111 0", stall, ens, fwd_a); end
    tick();
    clear_inputs();
    tick();
    mem_is_store = 1'b1; mem_addr_rt = 5'd5; wb_wen = 1'b1; wb_regw_addr = 5'd5;
    settle();
    checks++; if (fwd_mem !== 1'b1) begin errors++; $display("FAIL st_fwd_mem: got %0b want 1", fwd_mem); end
    wb_regw_addr = 5'd6;
    settle();
    checks++; if (fwd_mem !== 1'b0) begin errors++; $display("FAIL st_fwd_mem_miss: got %0b want 0", fwd_mem); end
    tick();
  endtask

  task automatic test_md();
    do_reset();
    id_is_md = 1'b1;
    settle();
    checks++; if (md_busy !== 1'b0 || stall !== 1'b0 || ens !== 5'h1f) begin errors++;
      $display("FAIL md_issue: got md_busy=%0b stall=%0b ens=%b want 0 0 11111", md_busy, stall, ens); end
    tick();
    id_is_md = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      settle();
      checks++; if (md_busy !== 1'b1 || stall !== 1'b1 || ens !== 5'b00011 || rsts !== 5'b00010) begin errors++;
        $display("FAIL md_busy_%0d: got busy=%0b stall=%0b ens=%b rsts=%b want 1 1 00011 00010", i, md_busy, stall, ens, rsts); end
      tick();
    end
    settle();
    checks++; if (md_busy !== 1'b0 || stall !== 1'b0 || ens !== 5'h1f || stall_cnt !== 32'd3) begin errors++;
      $display("FAIL md_done: got busy=%0b stall=%0b ens=%b stall_cnt=%0d want 0 0 11111 3", md_busy, stall, ens, stall_cnt); end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    id_redirect = 1'b1;
    settle();
    checks++; if (rsts !== 5'b10000 || ens !== 5'h1f) begin errors++;
      $display("FAIL rd_flush: got rsts=%b ens=%b want 10000 11111", rsts, ens); end
    checks++; if (ds_rsts !== 5'd0 || ds_ens !== 5'h1f || {ds_fwd_a, ds_fwd_b, ds_fwd_mem, ds_stall, ds_md_busy} !== 7'd0) begin errors++;
      $display("FAIL rd_delay_slot: got rsts=%b ens=%b want 00000 11111", ds_rsts, ds_ens); end
    tick();
    id_redirect = 1'b0;
    checks++; if (flush_cnt !== 32'd1 || ds_flush_cnt !== 2'd0) begin errors++;
      $display("FAIL rd_cnt: got flush_cnt=%0d ds_flush_cnt=%0d want 1 0", flush_cnt, ds_flush_cnt); end
    id_redirect = 1'b1; exe_regw_addr = 5'd4; exe_wb_wen = 1'b1; exe_is_load = 1'b1;
    id_rt_used = 1'b1; id_addr_rt = 5'd4;
    settle();
    checks++; if (if_rst !== 1'b0 || stall !== 1'b1) begin errors++;
      $display("FAIL rd_stalled: got if_rst=%0b stall=%0b want 0 1", if_rst, stall); end
    tick();
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL rd_stalled_cnt: got %0d want 1", flush_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    exe_regw_addr = 5'd5; exe_wb_wen = 1'b1; exe_is_load = 1'b1; id_rs_used = 1'b1; id_addr_rs = 5'd5;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (stall_cnt !== 32'd5 || ds_stall_cnt !== 2'd3) begin errors++;
      $display("FAIL sat_cnt: got stall_cnt=%0d ds_stall_cnt=%0d want 5 3", stall_cnt, ds_stall_cnt); end
  endtask

  task automatic test_debug();
    do_reset();
    id_is_md = 1'b1;
    tick();
    id_is_md = 1'b0; debug_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      checks++; if (md_busy !== 1'b1 || ens !== 5'd0) begin errors++;
        $display("FAIL dbg_hold_%0d: got busy=%0b ens=%b want 1 00000", i, md_busy, ens); end
      tick();
    end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL dbg_hold_cnt: got %0d want 0", stall_cnt); end
    for (int s = 1; s <= 2; s++) begin
      debug_step = 1'b1;
      settle();
      checks++; if (ens !== 5'b00011 || stall !== 1'b1) begin errors++;
        $display("FAIL dbg_step_%0d: got ens=%b stall=%0b want 00011 1", s, ens, stall); end
      tick();
      settle();
      checks++; if (ens !== 5'd0) begin errors++; $display("FAIL dbg_step_held_%0d: got ens=%b want 00000", s, ens); end
      tick();
      debug_step = 1'b0;
      tick();
      checks++; if (stall_cnt !== 32'(s) || md_busy !== 1'b1) begin errors++;
        $display("FAIL dbg_step_cnt_%0d: got stall_cnt=%0d busy=%0b want %0d 1", s, stall_cnt, md_busy, s); end
    end
    rst = 1'b0;
    tick();
    rst = 1'b1; debug_en = 1'b0;
    settle();
    checks++; if (md_busy !== 1'b0 || stall !== 1'b0 || ens !== 5'h1f || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++;
      $display("FAIL dbg_rst_busy: got busy=%0b stall=%0b ens=%b stall_cnt=%0d flush_cnt=%0d want 0 0 11111 0 0",
               md_busy, stall, ens, stall_cnt, flush_cnt); end
    tick();
  endtask

  task automatic test_random();
    int busy_left = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit prev_step = 1'b0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bit frz, ea, eb, ma, mb, haz, e_stall, e_ifrst;
      logic [4:0] e_ens, e_rsts;
      logic [1:0] ea_f, eb_f;
      debug_en = ($urandom_range(0, 7) == 0); debug_step = 1'($urandom);
      id_rs_used = 1'($urandom); id_rt_used = 1'($urandom);
      id_addr_rs = AW'($urandom_range(0, 3)); id_addr_rt = AW'($urandom_range(0, 3));
      id_is_store = 1'($urandom); id_is_md = ($urandom_range(0, 7) == 0); id_redirect = 1'($urandom);
      exe_regw_addr = AW'($urandom_range(0, 3)); exe_wb_wen = 1'($urandom); exe_is_load = 1'($urandom);
      mem_regw_addr = AW'($urandom_range(0, 3)); mem_wb_wen = 1'($urandom); mem_is_load = 1'($urandom);
      mem_is_store = 1'($urandom); mem_addr_rt = AW'($urandom_range(0, 3));
      wb_regw_addr = AW'($urandom_range(0, 3)); wb_wen = 1'($urandom);
      settle();
      frz = debug_en && !(debug_step && !prev_step);
      ea = id_rs_used && id_addr_rs != 0 && exe_wb_wen && exe_regw_addr == id_addr_rs;
      eb = id_rt_used && id_addr_rt != 0 && exe_wb_wen && exe_regw_addr == id_addr_rt;
      ma = id_rs_used && id_addr_rs != 0 && mem_wb_wen && mem_regw_addr == id_addr_rs;
      mb = id_rt_used && id_addr_rt != 0 && mem_wb_wen && mem_regw_addr == id_addr_rt;
      haz = exe_is_load && (ea || (eb && !id_is_store));
      ea_f = ea ? 2'd1 : (ma ? (mem_is_load ? 2'd3 : 2'd2) : 2'd0);
      eb_f = eb ? 2'd1 : (mb ? (mem_is_load ? 2'd3 : 2'd2) : 2'd0);
      e_stall = (busy_left > 0) || haz;
      e_ifrst = !e_stall && id_redirect;
      if (busy_left > 0) begin e_ens = 5'b00011; e_rsts = 5'b00010; end
      else if (haz) begin e_ens = 5'b00111; e_rsts = 5'b00100; end
      else begin e_ens = 5'h1f; e_rsts = {e_ifrst, 4'b0000}; end
      if (!(ea && exe_is_load)) begin
        checks++; if (fwd_a !== ea_f) begin errors++; $display("FAIL rnd_fwd_a @%0d: got %0d want %0d", n, fwd_a, ea_f); end
      end
      if (!(eb && exe_is_load)) begin
        checks++; if (fwd_b !== eb_f) begin errors++; $display("FAIL rnd_fwd_b @%0d: got %0d want %0d", n, fwd_b, eb_f); end
      end
      checks++; if (fwd_mem !== (mem_is_store && mem_addr_rt != 0 && wb_wen && wb_regw_addr == mem_addr_rt)) begin errors++;
        $display("FAIL rnd_fwd_mem @%0d: got %0b", n, fwd_mem); end
      checks++; if (md_busy !== (busy_left > 0)) begin errors++;
        $display("FAIL rnd_md_busy @%0d: got %0b want %0b", n, md_busy, busy_left > 0); end
      if (frz) begin
        checks++; if (ens !== 5'd0) begin errors++; $display("FAIL rnd_frozen @%0d: got ens=%b want 00000", n, ens); end
      end else begin
        checks++; if (ens !== e_ens || rsts !== e_rsts || stall !== e_stall) begin errors++;
          $display("FAIL rnd_ctl @%0d: got ens=%b rsts=%b stall=%0b want %b %b %0b", n, ens, rsts, stall, e_ens, e_rsts, e_stall); end
      end
      tick();
      if (!frz) begin
        if (e_stall) m_stall++;
        if (e_ifrst) m_flush++;
        if (busy_left > 0) busy_left--;
        else if (!haz && id_is_md) busy_left = LAT - 1;
      end
      prev_step = debug_step;
      checks++; if (stall_cnt !== 32'(m_stall) || flush_cnt !== 32'(m_flush)) begin errors++;
        $display("FAIL rnd_cnt @%0d: got %0d %0d want %0d %0d", n, stall_cnt, flush_cnt, m_stall, m_flush); end
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_store();
    test_md();
    test_redirect();
    test_saturate();
    test_debug();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
